corr_window_feeder: RTL and testbench
=====================================

Name: corr_window_feeder

Overview:
- Upstream stage of the oversampled correlator.
- Deserialises two oversampled serial streams, reference and received, into SAMPLES*OSF-bit parallel windows and drives them onto the correlator's DataIn1/DataIn2 inputs.
- Sequences the correlator's precharge/evaluate control P.
- Captures the correlator's single-bit DataOut into a registered, validated result.

Parameters:
- SAMPLES, 2: symbols per correlation window.
- OSF, 8: oversampling factor, in samples per symbol.
- PRE_CYCLES, 2: clock cycles P is held high before each evaluation; minimum 1.
- EVAL_CYCLES, 4: clock cycles P is held low for each evaluation; minimum 1.
- W = SAMPLES*OSF (derived, not overridable): window width.

Ports:
- clk  in  1  single system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- Start  in  1  arm one capture; honoured only in IDLE.
- Continuous  in  1  when 1, re-enter FILL after each result instead of returning to IDLE.
- SampleEn  in  1  qualifies SerIn1/SerIn2 in the current cycle.
- SerIn1  in  1  reference stream, one oversample per SampleEn.
- SerIn2  in  1  received stream, one oversample per SampleEn.
- DataIn1  out  W  parallel reference window to the correlator.
- DataIn2  out  W  parallel received window to the correlator.
- P  out  1  correlator precharge: 1 = precharge, 0 = evaluate.
- ResultIn  in  1  correlator DataOut.
- Result  out  1  registered correlation result.
- ResultValid  out  1  one-cycle strobe; Result is valid while it is high.
- Busy  out  1  high in any state other than IDLE.
- Overrun  out  1  sticky flag: a sample was dropped.

Behaviour:
- Reset: asynchronous and active-high. Asserting rst forces immediately, including mid-operation:
  - state = IDLE, P = 1, all other outputs 0;
  - shift registers, sample counter and phase counter cleared.
- FSM states: IDLE, FILL, PRE, EVAL. P is 1 in every state except EVAL.
- IDLE:
  - Busy = 0.
  - Start = 1: clear the sample counter and shift registers, clear Overrun, go to FILL.
- FILL, on each cycle with SampleEn = 1:
  - both shift registers shift left with SerIn into bit 0, so the first sample ends in bit W-1;
  - the sample counter increments.
- FILL end: on the edge that accepts the W-th sample:
  - DataIn1/DataIn2 load the completed words, including that sample;
  - the sample counter clears;
  - state moves to PRE.
- FILL with SampleEn = 0: hold.
- PRE: P = 1 for exactly PRE_CYCLES cycles, counted by the phase counter, then go to EVAL.
- EVAL: P = 0 for exactly EVAL_CYCLES cycles.
  - ResultIn is sampled on the edge that ends the last EVAL cycle.
  - In the following cycle, Result = the sampled value and ResultValid = 1 for exactly one cycle.
  - In that same cycle, state is FILL if Continuous = 1, otherwise IDLE, and P = 1.
- DataIn1/DataIn2 change only on the FILL-to-PRE edge and stay stable through PRE and EVAL.
- Result holds its value until the next result; only ResultValid is a strobe.
- SampleEn = 1 during PRE or EVAL: the sample is dropped and Overrun is set; Overrun clears only on an accepted Start.
- Start outside IDLE is ignored.
- Start and SampleEn together in IDLE: the sample is not captured; capture begins the next cycle.
- Continuous is sampled at the EVAL-exit edge only.
- Counters:
  - sample counter width = clog2(W+1);
  - phase counter width = clog2(max(PRE_CYCLES, EVAL_CYCLES)+1);
  - no wrap-around is reachable.
- Latency with SampleEn tied high: Start at cycle 0, then:
  - FILL occupies cycles 1..W;
  - PRE occupies cycles W+1..W+PRE_CYCLES;
  - EVAL follows;
  - ResultValid at cycle W+PRE_CYCLES+EVAL_CYCLES+1.

Test Plan:
- Basic fill, defaults (W=16). Pulse Start, hold SampleEn = 1, drive SerIn1 = 16'hA5C3 and SerIn2 = 16'h3C5A MSB-first. Required: DataIn1 = 16'hA5C3 and DataIn2 = 16'h3C5A from cycle 17; P = 1 at cycles 17-18 and 0 at cycles 19-22; ResultValid at cycle 23.
- Result capture. Tie ResultIn = 1 during EVAL. Required: Result = 1 with a one-cycle ResultValid, then IDLE with P = 1 and Busy = 0. Repeat with ResultIn = 0: Result = 0.
- Gapped SampleEn. Assert SampleEn on alternate cycles. Required: same words as the basic-fill case, completed at cycle 32; PRE starts at cycle 33.
- Continuous mode. Continuous = 1, three back-to-back windows. Required: three ResultValid pulses; Busy stays 1 throughout; P returns to 1 on each FILL re-entry.
- Overrun and ignored Start. Assert SampleEn and Start during EVAL. Required: Overrun = 1; FSM timing unchanged; DataIn stable. The next Start in IDLE clears Overrun.
- Reset mid-EVAL. Assert rst while P = 0. Required: P = 1 and DataIn = 0 immediately, without waiting for a clock edge; no ResultValid; state IDLE after release.

Source files
------------

// File: rtl/corr_window_feeder.sv
// corr_window_feeder: deserialises reference/received oversampled streams into
// parallel windows, sequences correlator precharge/evaluate and captures its result.
module corr_window_feeder #(
    parameter int SAMPLES     = 2,
    parameter int OSF         = 8,
    parameter int PRE_CYCLES  = 2,
    parameter int EVAL_CYCLES = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     Start,
    input  logic                     Continuous,
    input  logic                     SampleEn,
    input  logic                     SerIn1,
    input  logic                     SerIn2,
    output logic [SAMPLES*OSF-1:0]   DataIn1,
    output logic [SAMPLES*OSF-1:0]   DataIn2,
    output logic                     P,
    input  logic                     ResultIn,
    output logic                     Result,
    output logic                     ResultValid,
    output logic                     Busy,
    output logic                     Overrun
);
    localparam int W    = SAMPLES * OSF;
    localparam int PMAX = (PRE_CYCLES > EVAL_CYCLES) ? PRE_CYCLES : EVAL_CYCLES;
    localparam int CW   = $clog2(W + 1);
    localparam int PW   = $clog2(PMAX + 1);
    localparam logic [CW-1:0] CNT_LAST  = CW'(W - 1);
    localparam logic [PW-1:0] PRE_LAST  = PW'(PRE_CYCLES - 1);
    localparam logic [PW-1:0] EVAL_LAST = PW'(EVAL_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, FILL, PRE, EVAL} state_t;

    state_t          r_state;
    logic [W-1:0]    r_sh1, r_sh2, r_d1, r_d2;
    logic [CW-1:0]   r_cnt;
    logic [PW-1:0]   r_ph;
    logic            r_p, r_res, r_valid, r_busy, r_ovr;
    logic [W-1:0]    w_sh1, w_sh2;

    // First sample accepted ends up in the MSB once the window is full
    assign w_sh1 = {r_sh1[W-2:0], SerIn1};
    assign w_sh2 = {r_sh2[W-2:0], SerIn2};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_sh1   <= '0;
            r_sh2   <= '0;
            r_d1    <= '0;
            r_d2    <= '0;
            r_cnt   <= '0;
            r_ph    <= '0;
            r_p     <= 1'b1;
            r_res   <= 1'b0;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_ovr   <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                IDLE: if (Start) begin
                    r_cnt   <= '0;
                    r_sh1   <= '0;
                    r_sh2   <= '0;
                    r_ovr   <= 1'b0;
                    r_busy  <= 1'b1;
                    r_state <= FILL;
                end
                FILL: if (SampleEn) begin
                    r_sh1 <= w_sh1;
                    r_sh2 <= w_sh2;
                    if (r_cnt == CNT_LAST) begin
                        r_d1    <= w_sh1;
                        r_d2    <= w_sh2;
                        r_cnt   <= '0;
                        r_ph    <= '0;
                        r_state <= PRE;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                PRE: begin
                    r_ovr <= r_ovr | SampleEn;
                    if (r_ph == PRE_LAST) begin
                        r_ph    <= '0;
                        r_p     <= 1'b0;
                        r_state <= EVAL;
                    end else begin
                        r_ph <= r_ph + PW'(1);
                    end
                end
                EVAL: begin
                    r_ovr <= r_ovr | SampleEn;
                    if (r_ph == EVAL_LAST) begin
                        r_ph    <= '0;
                        r_p     <= 1'b1;
                        r_res   <= ResultIn;
                        r_valid <= 1'b1;
                        r_busy  <= Continuous;
                        r_state <= Continuous ? FILL : IDLE;
                    end else begin
                        r_ph <= r_ph + PW'(1);
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign DataIn1     = r_d1;
    assign DataIn2     = r_d2;
    assign P           = r_p;
    assign Result      = r_res;
    assign ResultValid = r_valid;
    assign Busy        = r_busy;
    assign Overrun     = r_ovr;
endmodule

// File: tb/tb_corr_window_feeder.sv
// tb_corr_window_feeder: directed checks of fill, timing, result capture,
// continuous mode, overrun and asynchronous reset with the default 16-bit window.
module tb_corr_window_feeder;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        Start = 1'b0, Continuous = 1'b0, SampleEn = 1'b0;
    logic        SerIn1 = 1'b0, SerIn2 = 1'b0, ResultIn = 1'b0;
    logic [15:0] DataIn1, DataIn2;
    logic        P, Result, ResultValid, Busy, Overrun;
    int          tot = 0;
    int          bad = 0;

    corr_window_feeder dut (
        .clk(clk), .rst(rst), .Start(Start), .Continuous(Continuous),
        .SampleEn(SampleEn), .SerIn1(SerIn1), .SerIn2(SerIn2),
        .DataIn1(DataIn1), .DataIn2(DataIn2), .P(P), .ResultIn(ResultIn),
        .Result(Result), .ResultValid(ResultValid), .Busy(Busy), .Overrun(Overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tot++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // rel counts cycles from the Start cycle (rel 0); fe is the cycle whose
    // closing edge accepts the last sample. Ends in the ResultValid cycle.
    task automatic window(input logic [15:0] a, input logic [15:0] b, input bit gap,
                          input bit res, input bit cont, input bit ovr,
                          input bit started, input int rst_at);
        int fe = gap ? 32 : 16;
        int k  = 0;
        int rel = 1;
        if (!started) begin
            SampleEn = 1'b0;
            Start    = 1'b1;
            tick();
            Start = 1'b0;
        end
        Continuous = cont;
        ResultIn   = res;
        while (rel <= fe + 6) begin
            if (rel == 1 && !started) check("ovr_clr", Overrun, 0);
            check("p", P, (rel >= fe + 3) ? 0 : 1);
            check("busy", Busy, 1);
            if (rel > 1) check("rv_lo", ResultValid, 0);
            if (rel > fe) begin
                check("d1", DataIn1, a);
                check("d2", DataIn2, b);
            end
            if (rel == rst_at) begin
                rst = 1'b1;
                #1;
                check("rst_p", P, 1);
                check("rst_d1", DataIn1, 0);
                check("rst_d2", DataIn2, 0);
                check("rst_busy", Busy, 0);
                check("rst_rv", ResultValid, 0);
                SampleEn = 1'b0;
                Start    = 1'b0;
                tick();
                rst = 1'b0;
                repeat (8) begin
                    tick();
                    check("post_rst_rv", ResultValid, 0);
                    check("post_rst_busy", Busy, 0);
                    check("post_rst_p", P, 1);
                end
                return;
            end
            SampleEn = 1'b0;
            Start    = 1'b0;
            if (rel <= fe && (!gap || rel % 2 == 0)) begin
                SampleEn = 1'b1;
                SerIn1   = a[15-k];
                SerIn2   = b[15-k];
                k++;
            end
            if (ovr && rel == fe + 4) begin
                SampleEn = 1'b1;
                Start    = 1'b1;
            end
            tick();
            rel++;
        end
        SampleEn = 1'b0;
        Start    = 1'b0;
        check("rv", ResultValid, 1);
        check("result", Result, res);
        check("p_exit", P, 1);
        check("busy_exit", Busy, cont);
        check("d1_exit", DataIn1, a);
        if (ovr) check("ovr_set", Overrun, 1);
    endtask

    initial begin
        tick();
        tick();
        check("r_p", P, 1);
        check("r_busy", Busy, 0);
        check("r_rv", ResultValid, 0);
        check("r_ovr", Overrun, 0);
        check("r_d1", DataIn1, 0);
        check("r_d2", DataIn2, 0);
        rst = 1'b0;
        tick();
        window(16'hA5C3, 16'h3C5A, 0, 1, 0, 0, 0, 0);
        tick();
        check("rv_strobe", ResultValid, 0);
        check("result_hold", Result, 1);
        check("idle_busy", Busy, 0);
        check("idle_p", P, 1);
        window(16'hA5C3, 16'h3C5A, 0, 0, 0, 0, 0, 0);
        tick();
        window(16'hA5C3, 16'h3C5A, 1, 1, 0, 0, 0, 0);
        tick();
        window(16'h0F71, 16'hE28B, 0, 0, 0, 1, 0, 0);
        tick();
        check("ovr_sticky", Overrun, 1);
        check("ovr_idle", Busy, 0);
        window(16'h1234, 16'hFEDC, 0, 1, 0, 0, 0, 0);
        tick();
        window(16'h8001, 16'h7FFE, 0, 1, 1, 0, 0, 0);
        window(16'hC3A5, 16'h5A3C, 0, 0, 1, 0, 1, 0);
        window(16'hFFFF, 16'h0000, 0, 1, 0, 0, 1, 0);
        tick();
        check("cont_end_busy", Busy, 0);
        window(16'hBEEF, 16'h4321, 0, 1, 0, 0, 0, 20);
        window(16'h5555, 16'hAAAA, 0, 0, 0, 0, 0, 0);
        $display("test done: total=%0d bad=%0d", tot, bad);
        $finish;
    end
endmodule
